// File: rtl/dbg_cmd_pkg.sv
// Shared types and constants for the debug-command system-clock queue.
package dbg_cmd_pkg;

  localparam int unsigned IR_WIDTH_DEFAULT = 2;
  localparam int unsigned DR_WIDTH_DEFAULT = 38;
  localparam int unsigned ACT_BIT_DEFAULT  = 34;

  // One queued debug command at the default widths.
  typedef struct packed {
    logic [IR_WIDTH_DEFAULT-1:0] ir;
    logic                        act;
    logic [DR_WIDTH_DEFAULT-1:0] data;
  } cmd_entry_t;

  // Ceiling log2; usable in parameter/localparam expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dbg_pulse_sync.sv
// Level synchroniser with history flop and post-reset arm mask; emits a
// registered one-cycle pulse on each synchronised rising edge.
module dbg_pulse_sync
  import dbg_cmd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic level_i,
  output logic pulse_o
);

  localparam int unsigned ARM_COUNT = SYNC_STAGES + 1;
  localparam int unsigned CNT_W     = clog2(ARM_COUNT + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [CNT_W-1:0]       arm_cnt_q, arm_cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   armed_s;

  // Next-state for synchroniser chain, history, arm counter and pulse.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], level_i};
    hist_d  = sync_q[SYNC_STAGES-1];
    armed_s = (arm_cnt_q == CNT_W'(ARM_COUNT));
    if (armed_s) begin
      arm_cnt_d = arm_cnt_q;
    end else begin
      arm_cnt_d = arm_cnt_q + CNT_W'(1);
    end
    // A level already high at reset release rises through the chain before
    // the counter arms, so it is masked here.
    pulse_d = sync_q[SYNC_STAGES-1] & ~hist_q & armed_s;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      arm_cnt_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      arm_cnt_q <= arm_cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/dbg_cmd_sysclk_queue.sv
// System-clock half of the JTAG debug slave: synchronises update-IR/DR,
// decodes action strobes and queues captured commands.
// Optional build macro DBG_CMD_STATS_EN adds stat_cmds / stat_drops counters.
module dbg_cmd_sysclk_queue
  import dbg_cmd_pkg::*;
#(
  parameter int unsigned IR_WIDTH    = IR_WIDTH_DEFAULT,
  parameter int unsigned DR_WIDTH    = DR_WIDTH_DEFAULT,
  parameter int unsigned ACT_BIT     = ACT_BIT_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vs_uir,
  input  logic                     vs_udr,
  input  logic [IR_WIDTH-1:0]      ir_in,
  input  logic [DR_WIDTH-1:0]      sr,
  output logic [DR_WIDTH-1:0]      jdo,
  output logic [(2**IR_WIDTH)-1:0] take_action,
  output logic [(2**IR_WIDTH)-1:0] take_no_action,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [IR_WIDTH-1:0]      cmd_ir,
  output logic                     cmd_act,
  output logic [DR_WIDTH-1:0]      cmd_data,
  output logic                     overflow,
  input  logic                     clear_overflow
`ifdef DBG_CMD_STATS_EN
  ,
  output logic [15:0]              stat_cmds,
  output logic [15:0]              stat_drops
`endif
);

  localparam int unsigned NUM_IR = 2 ** IR_WIDTH;
  localparam int unsigned AW     = clog2(DEPTH);
  localparam int unsigned PW     = AW + 1;

  logic                uir_pulse_s, udr_pulse_s;
  logic                act_bit_s;
  logic [NUM_IR-1:0]   onehot_s;
  logic                full_s, pop_s, push_s, drop_s;

  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [DR_WIDTH-1:0] jdo_q, jdo_d;
  logic [NUM_IR-1:0]   take_action_q, take_action_d;
  logic [NUM_IR-1:0]   take_no_action_q, take_no_action_d;

  logic [IR_WIDTH-1:0] mem_ir_q   [DEPTH];
  logic                mem_act_q  [DEPTH];
  logic [DR_WIDTH-1:0] mem_data_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [IR_WIDTH-1:0] cmd_ir_q, cmd_ir_d;
  logic                cmd_act_q, cmd_act_d;
  logic [DR_WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic                overflow_q, overflow_d;

  dbg_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
    .clk_i   (clk),
    .reset_i (reset),
    .level_i (vs_uir),
    .pulse_o (uir_pulse_s)
  );

  dbg_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
    .clk_i   (clk),
    .reset_i (reset),
    .level_i (vs_udr),
    .pulse_o (udr_pulse_s)
  );

  // Instruction latch, capture, strobe decode and queue control.
  always_comb begin
    act_bit_s = sr[ACT_BIT];
    onehot_s  = NUM_IR'(1) << ir_q;

    if (uir_pulse_s) begin
      ir_d = ir_in;
    end else begin
      ir_d = ir_q;
    end

    // Decode uses the current ir_q, so a coincident uir update is not seen.
    if (udr_pulse_s) begin
      jdo_d            = sr;
      take_action_d    = act_bit_s ? onehot_s : {NUM_IR{1'b0}};
      take_no_action_d = act_bit_s ? {NUM_IR{1'b0}} : onehot_s;
    end else begin
      jdo_d            = jdo_q;
      take_action_d    = {NUM_IR{1'b0}};
      take_no_action_d = {NUM_IR{1'b0}};
    end

    full_s = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_s  = cmd_valid_q & cmd_ready;
    push_s = udr_pulse_s & (~full_s | pop_s);
    drop_s = udr_pulse_s & full_s & ~pop_s;

    wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;

    // Head register: bypass the entry being written when it becomes the head.
    cmd_valid_d = (wr_ptr_d != rd_ptr_d);
    if (cmd_valid_d) begin
      if (push_s && (rd_ptr_d == wr_ptr_q)) begin
        cmd_ir_d   = ir_q;
        cmd_act_d  = act_bit_s;
        cmd_data_d = sr;
      end else begin
        cmd_ir_d   = mem_ir_q[rd_ptr_d[AW-1:0]];
        cmd_act_d  = mem_act_q[rd_ptr_d[AW-1:0]];
        cmd_data_d = mem_data_q[rd_ptr_d[AW-1:0]];
      end
    end else begin
      cmd_ir_d   = cmd_ir_q;
      cmd_act_d  = cmd_act_q;
      cmd_data_d = cmd_data_q;
    end

    // A drop wins over a same-cycle clear.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q             <= '0;
      jdo_q            <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      cmd_valid_q      <= 1'b0;
      cmd_ir_q         <= '0;
      cmd_act_q        <= 1'b0;
      cmd_data_q       <= '0;
      overflow_q       <= 1'b0;
    end else begin
      ir_q             <= ir_d;
      jdo_q            <= jdo_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      cmd_valid_q      <= cmd_valid_d;
      cmd_ir_q         <= cmd_ir_d;
      cmd_act_q        <= cmd_act_d;
      cmd_data_q       <= cmd_data_d;
      overflow_q       <= overflow_d;
    end
  end

  // Queue storage, written at the tail on each accepted push.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_ir_q[i]   <= '0;
        mem_act_q[i]  <= 1'b0;
        mem_data_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_ir_q[wr_ptr_q[AW-1:0]]   <= ir_q;
      mem_act_q[wr_ptr_q[AW-1:0]]  <= act_bit_s;
      mem_data_q[wr_ptr_q[AW-1:0]] <= sr;
    end
  end

  assign jdo            = jdo_q;
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign cmd_valid      = cmd_valid_q;
  assign cmd_ir         = cmd_ir_q;
  assign cmd_act        = cmd_act_q;
  assign cmd_data       = cmd_data_q;
  assign overflow       = overflow_q;

`ifdef DBG_CMD_STATS_EN
  logic [15:0] stat_cmds_q, stat_cmds_d;
  logic [15:0] stat_drops_q, stat_drops_d;

  // Saturating push/drop counters; a clear coinciding with an increment yields 1.
  always_comb begin
    if (clear_overflow) begin
      stat_cmds_d  = push_s ? 16'd1 : 16'd0;
      stat_drops_d = drop_s ? 16'd1 : 16'd0;
    end else begin
      stat_cmds_d  = (push_s && (stat_cmds_q != 16'hFFFF)) ? (stat_cmds_q + 16'd1) : stat_cmds_q;
      stat_drops_d = (drop_s && (stat_drops_q != 16'hFFFF)) ? (stat_drops_q + 16'd1) : stat_drops_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cmds_q  <= 16'd0;
      stat_drops_q <= 16'd0;
    end else begin
      stat_cmds_q  <= stat_cmds_d;
      stat_drops_q <= stat_drops_d;
    end
  end

  assign stat_cmds  = stat_cmds_q;
  assign stat_drops = stat_drops_q;
`endif

endmodule

// File: tb/tb_dbg_cmd_sysclk_queue.sv
// Self-checking bench for dbg_cmd_sysclk_queue with a queue-based reference model.
module tb_dbg_cmd_sysclk_queue;
  import dbg_cmd_pkg::*;

  localparam int S     = 2;
  localparam int DEPTH = 4;
  localparam int ACT   = 34;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vs_uir = 1'b0;
  logic        vs_udr = 1'b0;
  logic [1:0]  ir_in = 2'd0;
  logic [37:0] sr = 38'd0;
  logic [37:0] jdo;
  logic [3:0]  take_action, take_no_action;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [1:0]  cmd_ir;
  logic        cmd_act;
  logic [37:0] cmd_data;
  logic        overflow;
  logic        clear_overflow = 1'b0;
`ifdef DBG_CMD_STATS_EN
  logic [15:0] stat_cmds, stat_drops;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  cmd_entry_t model_q[$];
  logic [1:0] model_ir = 2'd0;
  logic       model_ov = 1'b0;
  int         model_cmds = 0;
  int         model_drops = 0;

  dbg_cmd_sysclk_queue #(
    .IR_WIDTH(2), .DR_WIDTH(38), .ACT_BIT(ACT), .SYNC_STAGES(S), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .ir_in(ir_in), .sr(sr), .jdo(jdo),
    .take_action(take_action), .take_no_action(take_no_action),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_act(cmd_act), .cmd_data(cmd_data),
    .overflow(overflow), .clear_overflow(clear_overflow)
`ifdef DBG_CMD_STATS_EN
    , .stat_cmds(stat_cmds), .stat_drops(stat_drops)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] rand_data();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[37:0];
  endfunction

  task automatic model_reset();
    model_q.delete();
    model_ir    = 2'd0;
    model_ov    = 1'b0;
    model_cmds  = 0;
    model_drops = 0;
  endtask

  // Latch an instruction through a full vs_uir high/low cycle.
  task automatic do_uir(input logic [1:0] v);
    @(negedge clk);
    ir_in  = v;
    vs_uir = 1'b1;
    repeat (S + 4) @(posedge clk);
    @(negedge clk);
    vs_uir = 1'b0;
    repeat (S + 3) @(posedge clk);
    model_ir = v;
  endtask

  // One update-DR command, checking strobe timing, capture and queue state.
  task automatic do_udr(input logic [37:0] data, input bit pop_during,
                        input bit clr_during, input bit with_uir, input logic [1:0] uir_val);
    logic [3:0] exp_a, exp_n, want_a, want_n;
    cmd_entry_t e;
    bit act;
    act   = data[ACT];
    exp_a = act ? (4'b0001 << model_ir) : 4'b0000;
    exp_n = act ? 4'b0000 : (4'b0001 << model_ir);
    e.ir = model_ir; e.act = act; e.data = data;
    @(negedge clk);
    sr     = data;
    vs_udr = 1'b1;
    if (with_uir) begin
      ir_in  = uir_val;
      vs_uir = 1'b1;
    end
    for (int k = 1; k <= S + 4; k++) begin
      @(posedge clk);
      #1;
      want_a = (k == S + 2) ? exp_a : 4'b0000;
      want_n = (k == S + 2) ? exp_n : 4'b0000;
      n_tests++;
      if (take_action !== want_a) begin
        n_fail++;
        $display("FAIL take_action cyc %0d: got %b expected %b", k, take_action, want_a);
      end
      n_tests++;
      if (take_no_action !== want_n) begin
        n_fail++;
        $display("FAIL take_no_action cyc %0d: got %b expected %b", k, take_no_action, want_n);
      end
      if (k == S + 1) begin
        if (pop_during && model_q.size() > 0) begin
          n_tests++;
          if ({cmd_ir, cmd_act, cmd_data} !== model_q[0]) begin
            n_fail++;
            $display("FAIL head_before_pop: got %h expected %h", {cmd_ir, cmd_act, cmd_data}, model_q[0]);
          end
        end
        cmd_ready      = pop_during;
        clear_overflow = clr_during;
      end
      if (k == S + 2) begin
        cmd_ready      = 1'b0;
        clear_overflow = 1'b0;
        n_tests++;
        if (jdo !== data) begin
          n_fail++;
          $display("FAIL jdo: got %h expected %h", jdo, data);
        end
        if (pop_during && model_q.size() > 0) void'(model_q.pop_front());
        if (model_q.size() < DEPTH) begin
          model_q.push_back(e);
          model_cmds  = clr_during ? 1 : ((model_cmds < 65535) ? model_cmds + 1 : model_cmds);
          model_drops = clr_during ? 0 : model_drops;
          model_ov    = clr_during ? 1'b0 : model_ov;
        end else begin
          model_ov    = 1'b1;
          model_drops = clr_during ? 1 : ((model_drops < 65535) ? model_drops + 1 : model_drops);
          model_cmds  = clr_during ? 0 : model_cmds;
        end
      end
    end
    if (with_uir) model_ir = uir_val;
    @(negedge clk);
    vs_udr = 1'b0;
    vs_uir = 1'b0;
    repeat (S + 3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (overflow !== model_ov) begin
      n_fail++;
      $display("FAIL overflow: got %b expected %b", overflow, model_ov);
    end
    n_tests++;
    if (cmd_valid !== (model_q.size() != 0)) begin
      n_fail++;
      $display("FAIL cmd_valid: got %b expected %b", cmd_valid, model_q.size() != 0);
    end
    if (model_q.size() != 0) begin
      n_tests++;
      if ({cmd_ir, cmd_act, cmd_data} !== model_q[0]) begin
        n_fail++;
        $display("FAIL head: got %h expected %h", {cmd_ir, cmd_act, cmd_data}, model_q[0]);
      end
    end
  endtask

  // Pop every modelled entry, checking order, then confirm empty.
  task automatic drain();
    for (int i = 0; i < DEPTH + 1 && model_q.size() > 0; i++) begin
      @(negedge clk);
      n_tests++;
      if (cmd_valid !== 1'b1 || {cmd_ir, cmd_act, cmd_data} !== model_q[0]) begin
        n_fail++;
        $display("FAIL drain_head %0d: got v=%b %h expected %h", i, cmd_valid,
                 {cmd_ir, cmd_act, cmd_data}, model_q[0]);
      end
      cmd_ready = 1'b1;
      @(posedge clk);
      #1;
      cmd_ready = 1'b0;
      void'(model_q.pop_front());
    end
    @(negedge clk);
    n_tests++;
    if (cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: got %b expected 0", cmd_valid);
    end
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    model_ov    = 1'b0;
    model_cmds  = 0;
    model_drops = 0;
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_overflow: got %b expected 0", overflow);
    end
  endtask

  // Checks that 20 cycles after reset release nothing is produced.
  task automatic check_quiet(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (take_action !== 4'b0 || take_no_action !== 4'b0 || cmd_valid !== 1'b0 ||
          overflow !== 1'b0 || jdo !== 38'd0) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got ta=%b tna=%b v=%b ov=%b jdo=%h expected all 0",
                 tag, i, take_action, take_no_action, cmd_valid, overflow, jdo);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset  = 1'b1;
    vs_udr = 1'b1;
    vs_uir = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_quiet("reset_quiet");
    @(negedge clk);
    vs_udr = 1'b0;
    vs_uir = 1'b0;
    repeat (S + 3) @(posedge clk);
  endtask

  task automatic test_action();
    do_uir(2'b01);
    do_udr(38'h3_0000_ABCD | (38'd1 << ACT), 1'b0, 1'b0, 1'b0, 2'b00);
    do_uir(2'b11);
    do_udr(38'h3_0000_ABCD, 1'b0, 1'b0, 1'b0, 2'b00);
    drain();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) do_udr(rand_data(), 1'b0, 1'b0, 1'b0, 2'b00);
    do_udr(rand_data(), 1'b0, 1'b1, 1'b0, 2'b00);
    drain();
    clear_pulse();
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) do_udr(rand_data(), 1'b0, 1'b0, 1'b0, 2'b00);
    do_udr(rand_data(), 1'b1, 1'b0, 1'b0, 2'b00);
    n_tests++;
    if (model_q.size() != DEPTH || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_push_pop: got ov=%b expected 0", overflow);
    end
    drain();
  endtask

  task automatic test_simultaneous();
    do_uir(2'b10);
    do_udr(rand_data(), 1'b0, 1'b0, 1'b1, 2'b11);
    do_udr(rand_data(), 1'b0, 1'b0, 1'b0, 2'b00);
    drain();
  endtask

  task automatic test_random();
    int c;
    for (int i = 0; i < 30; i++) begin
      c = $urandom_range(0, 9);
      if (c < 3) do_uir(2'($urandom_range(0, 3)));
      else if (c < 8) do_udr(rand_data(), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 2'b00);
      else drain();
    end
    drain();
    clear_pulse();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) do_udr(rand_data(), 1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    sr     = rand_data();
    vs_udr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_quiet("reset_mid_quiet");
    @(negedge clk);
    vs_udr = 1'b0;
    repeat (S + 3) @(posedge clk);
  endtask

`ifdef DBG_CMD_STATS_EN
  task automatic test_stats();
    clear_pulse();
    for (int i = 0; i < 5; i++) do_udr(rand_data(), 1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    n_tests++;
    if (stat_cmds !== 16'(model_cmds) || stat_drops !== 16'(model_drops)) begin
      n_fail++;
      $display("FAIL stats: got %0d/%0d expected %0d/%0d", stat_cmds, stat_drops, model_cmds, model_drops);
    end
    clear_pulse();
    n_tests++;
    if (stat_cmds !== 16'd0 || stat_drops !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_clear: got %0d/%0d expected 0/0", stat_cmds, stat_drops);
    end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_action();
    test_overflow();
    test_full_push_pop();
    test_simultaneous();
    test_random();
`ifdef DBG_CMD_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
